// File: rtl/coin_acceptor.sv
// Coin sensor front end: synchronizes and debounces the nickel/dime lines, queues
// accepted coins and emits each as a one-cycle code with at least one idle cycle between codes.
module coin_acceptor #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned FIFO_DEPTH      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       nickel_in,
    input  logic       dime_in,
    output logic [1:0] coin,
    output logic       coin_reject,
    output logic       busy
);

    localparam int unsigned CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned PW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CNTW = PW + 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNTW-1:0] CNT_FULL = CNTW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, EMIT, GAP} state_t;

    // Channel 0 is the nickel sensor, channel 1 is the dime sensor.
    logic [1:0]    raw;
    logic [1:0]    s1, s2, stable, rise;
    logic [CW-1:0] cnt [2];

    logic [1:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CNTW-1:0] count;

    state_t     state, state_next;
    logic [1:0] coin_next;
    logic       pop, push, both, full_after_pop, wr_en, overflow;
    logic [1:0] push_code;

    assign raw = {dime_in, nickel_in};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1     <= '0;
            s2     <= '0;
            stable <= '0;
            for (int unsigned i = 0; i < 2; i++) cnt[i] <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            for (int unsigned i = 0; i < 2; i++) begin
                if (s2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    stable[i] <= s2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // A coin event is the edge on which the stable level is about to go 0 -> 1.
    always_comb begin
        rise = '0;
        for (int unsigned i = 0; i < 2; i++)
            rise[i] = s2[i] & ~stable[i] & (cnt[i] == CNT_LAST);
    end

    assign both           = &rise;
    assign push           = rise[0] ^ rise[1];
    assign push_code      = rise[0] ? 2'b01 : 2'b10;
    assign full_after_pop = (count == CNT_FULL) && !pop;
    assign wr_en          = push && !full_after_pop;
    assign overflow       = push && full_after_pop;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= push_code;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        coin_next  = 2'b00;
        pop        = 1'b0;
        case (state)
            IDLE, GAP: begin
                if (count != '0) begin
                    pop        = 1'b1;
                    coin_next  = mem[rd_ptr];
                    state_next = EMIT;
                end else begin
                    state_next = IDLE;
                end
            end
            EMIT:    state_next = GAP;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            coin        <= 2'b00;
            coin_reject <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_next;
            coin        <= coin_next;
            coin_reject <= both | overflow;
            busy        <= (count != '0) || (state != IDLE);
        end
    end

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor: a default instance for debounce/latency cases and a
// DEBOUNCE_CYCLES=1 instance that can produce events fast enough for burst and overflow cases.
module tb_coin_acceptor;

    logic       clk = 1'b0;
    logic       rst, nickel_in, dime_in;
    logic [1:0] coin;
    logic       coin_reject, busy;
    logic       rst_f, nickel_f, dime_f;
    logic [1:0] coin_f;
    logic       reject_f, busy_f;

    int checks = 0;
    int errors = 0;
    int coins_seen, rej_seen;
    logic [1:0] last_coin;
    logic [1:0] got_q [$];

    typedef struct {
        logic       n;
        logic       d;
        logic [1:0] coin;
        logic       rej;
        logic       busy;
    } vec_t;

    localparam int unsigned NVEC = 30;
    vec_t vecs [NVEC];

    coin_acceptor #(.DEBOUNCE_CYCLES(4), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .nickel_in(nickel_in), .dime_in(dime_in),
        .coin(coin), .coin_reject(coin_reject), .busy(busy)
    );

    coin_acceptor #(.DEBOUNCE_CYCLES(1), .FIFO_DEPTH(4)) dut_fast (
        .clk(clk), .rst(rst_f), .nickel_in(nickel_f), .dime_in(dime_f),
        .coin(coin_f), .coin_reject(reject_f), .busy(busy_f)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive_slow(input logic n, input logic d, input int unsigned cycles);
        for (int unsigned i = 0; i < cycles; i++) begin
            nickel_in = n;
            dime_in   = d;
            tick();
            if (coin != 2'b00) begin
                coins_seen++;
                last_coin = coin;
            end
            if (coin_reject) rej_seen++;
        end
    endtask

    task automatic drive_fast(input logic n, input logic d, input int unsigned cycles);
        for (int unsigned i = 0; i < cycles; i++) begin
            nickel_f = n;
            dime_f   = d;
            tick();
            if (coin_f != 2'b00) got_q.push_back(coin_f);
            if (reject_f) rej_seen++;
        end
    endtask

    initial begin
        logic [1:0] burst_exp [5];
        logic [1:0] ovf_exp [8];
        int unsigned w;

        // Single nickel held 10 cycles, then a dime held 5 cycles; row r inputs are
        // sampled at edge r+1 and its outputs are observed just after that edge.
        for (int unsigned i = 0; i < NVEC; i++) vecs[i] = '{1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
        for (int unsigned i = 0; i < 10; i++) vecs[i].n = 1'b1;
        vecs[6].coin = 2'b01;
        vecs[6].busy = 1'b1;
        vecs[7].busy = 1'b1;
        vecs[8].busy = 1'b1;
        for (int unsigned i = 16; i < 21; i++) vecs[i].d = 1'b1;
        vecs[22].coin = 2'b10;
        vecs[22].busy = 1'b1;
        vecs[23].busy = 1'b1;
        vecs[24].busy = 1'b1;

        burst_exp = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
        ovf_exp   = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};

        rst = 1'b1; nickel_in = 1'b0; dime_in = 1'b0;
        rst_f = 1'b1; nickel_f = 1'b0; dime_f = 1'b0;
        tick();
        tick();
        check("reset_coin", coin, 2'b00);
        check("reset_reject", coin_reject, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_fast_coin", coin_f, 2'b00);
        check("reset_fast_busy", busy_f, 1'b0);
        rst = 1'b0;
        rst_f = 1'b0;

        for (int unsigned i = 0; i < NVEC; i++) begin
            nickel_in = vecs[i].n;
            dime_in   = vecs[i].d;
            tick();
            check($sformatf("vec%0d_coin", i), coin, vecs[i].coin);
            check($sformatf("vec%0d_reject", i), coin_reject, vecs[i].rej);
            check($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
        end
        drive_slow(1'b0, 1'b0, 10);

        // Bounce shorter than the debounce window must vanish.
        coins_seen = 0; rej_seen = 0;
        drive_slow(1'b1, 1'b0, 1);
        drive_slow(1'b0, 1'b0, 1);
        drive_slow(1'b1, 1'b0, 1);
        drive_slow(1'b0, 1'b0, 20);
        check("bounce_coins", coins_seen, 0);
        check("bounce_rejects", rej_seen, 0);

        coins_seen = 0; rej_seen = 0;
        drive_slow(1'b1, 1'b0, 3);
        drive_slow(1'b0, 1'b0, 20);
        check("pulse3_coins", coins_seen, 0);
        check("pulse3_rejects", rej_seen, 0);

        coins_seen = 0; rej_seen = 0; last_coin = 2'b00;
        drive_slow(1'b1, 1'b0, 6);
        drive_slow(1'b0, 1'b0, 20);
        check("pulse6_coins", coins_seen, 1);
        check("pulse6_code", last_coin, 2'b01);
        check("pulse6_rejects", rej_seen, 0);

        // Both sensors rise together: one reject pulse, nothing emitted.
        coins_seen = 0; rej_seen = 0;
        drive_slow(1'b1, 1'b1, 8);
        drive_slow(1'b0, 1'b0, 25);
        check("simul_coins", coins_seen, 0);
        check("simul_reject_cycles", rej_seen, 1);
        check("simul_busy_after", busy, 1'b0);

        // Burst on the fast instance: nickel, dime, nickel events on consecutive edges.
        rej_seen = 0;
        got_q.delete();
        drive_fast(1'b1, 1'b0, 1);
        drive_fast(1'b0, 1'b1, 1);
        drive_fast(1'b1, 1'b0, 1);
        nickel_f = 1'b0; dime_f = 1'b0;
        check("burst_early_coins", got_q.size(), 0);
        w = 0;
        while (coin_f == 2'b00 && w < 20) begin
            tick();
            w++;
        end
        check("burst_started", (w < 20), 1);
        for (int unsigned k = 0; k < 5; k++) begin
            check($sformatf("burst_coin%0d", k), coin_f, burst_exp[k]);
            if (reject_f) rej_seen++;
            tick();
        end
        drive_fast(1'b0, 1'b0, 10);
        check("burst_rejects", rej_seen, 0);
        check("burst_busy_after", busy_f, 1'b0);

        // Nine events on consecutive edges against a drain of one per two cycles:
        // the first eight fit (the eighth via push+pop on a full buffer), the ninth is dropped.
        rej_seen = 0;
        got_q.delete();
        for (int unsigned j = 0; j < 9; j++) drive_fast((j % 2) == 0, (j % 2) == 1, 1);
        drive_fast(1'b0, 1'b0, 30);
        check("ovf_coin_count", got_q.size(), 8);
        for (int unsigned k = 0; k < 8; k++) begin
            if (k < got_q.size()) check($sformatf("ovf_coin%0d", k), got_q[k], ovf_exp[k]);
            else check($sformatf("ovf_coin%0d", k), 2'b11, ovf_exp[k]);
        end
        check("ovf_rejects", rej_seen, 1);
        check("ovf_busy_after", busy_f, 1'b0);

        // Reset with coins still queued: outputs clear at once, nothing comes out afterwards.
        drive_fast(1'b1, 1'b0, 1);
        drive_fast(1'b0, 1'b1, 1);
        drive_fast(1'b1, 1'b0, 1);
        drive_fast(1'b0, 1'b1, 1);
        drive_fast(1'b0, 1'b0, 2);
        check("midrst_busy_before", busy_f, 1'b1);
        rst_f = 1'b1;
        #1;
        check("midrst_coin", coin_f, 2'b00);
        check("midrst_reject", reject_f, 1'b0);
        check("midrst_busy", busy_f, 1'b0);
        tick();
        tick();
        rst_f = 1'b0;
        got_q.delete();
        rej_seen = 0;
        drive_fast(1'b0, 1'b0, 20);
        check("postrst_coins", got_q.size(), 0);
        check("postrst_rejects", rej_seen, 0);
        check("postrst_busy", busy_f, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
